fifo_parser_sched: RTL

Read-side sequencer between the 64-bit market-data FIFO (scfifo64x256, non-showahead) and MDP3_Parser. It issues FIFO read requests, absorbs the one-cycle FIFO read latency with a 2-entry output buffer, and presents words to the parser through a valid/ready handshake at up to one word per clock. It also drives a hysteretic throttle back toward the packetizer, supports a flush/drain operation, and keeps forwarded-word and stall counters.

---
 rtl/fifo_parser_sched_if.sv | 26 ++
 rtl/fifo_parser_sched.sv | 115 +++++++++++
 2 files changed

// File: rtl/fifo_parser_sched_if.sv
// Handshake bundle between the read sequencer, the scfifo64x256 read port,
// the MDP3 parser and the packetizer throttle.
interface fifo_parser_sched_if;
   logic        fifo_empty;
   logic        fifo_full;
   logic [7:0]  fifo_usedw;
   logic [63:0] fifo_q;
   logic        fifo_rdreq;
   logic [63:0] msg_data;
   logic        msg_valid;
   logic        msg_ready;
   logic        flush;
   logic        throttle;
   logic [31:0] words_fwd;
   logic [15:0] stall_cycles;

   modport master (
      input  fifo_empty, fifo_full, fifo_usedw, fifo_q, msg_ready, flush,
      output fifo_rdreq, msg_data, msg_valid, throttle, words_fwd, stall_cycles
   );

   modport slave (
      output fifo_empty, fifo_full, fifo_usedw, fifo_q, msg_ready, flush,
      input  fifo_rdreq, msg_data, msg_valid, throttle, words_fwd, stall_cycles
   );
endinterface

// File: rtl/fifo_parser_sched.sv
// Read-side sequencer: pulls words from a non-showahead FIFO into a 2-entry
// buffer, presents them to the parser, drives throttle, supports flush.
module fifo_parser_sched #(
   parameter int unsigned HI_WM = 224,
   parameter int unsigned LO_WM = 192
) (
   input  logic                clk,
   input  logic                reset,
   fifo_parser_sched_if.master bus
);

   localparam logic [8:0] HI_LVL = 9'(HI_WM);
   localparam logic [8:0] LO_LVL = 9'(LO_WM);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state;
   logic [1:0]  occ;
   logic        pend;
   logic [63:0] word0;
   logic [63:0] word1;
   logic        throttle_q;
   logic [31:0] words_fwd_q;
   logic [15:0] stall_q;

   logic        pop;
   logic        stall;
   logic [2:0]  fill;
   logic [8:0]  level;

   assign bus.msg_valid    = (occ != 2'd0);
   assign bus.msg_data     = word0;
   assign bus.throttle     = throttle_q;
   assign bus.words_fwd    = words_fwd_q;
   assign bus.stall_cycles = stall_q;

   assign pop   = bus.msg_valid & bus.msg_ready;
   assign stall = bus.msg_valid & ~bus.msg_ready;
   // Projected occupancy once the in-flight read lands and this cycle's pop leaves.
   assign fill  = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
   assign level = bus.fifo_full ? 9'd256 : {1'b0, bus.fifo_usedw};

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      bus.fifo_rdreq = 1'b0;
      if (state == FLUSH) bus.fifo_rdreq = ~bus.fifo_empty;
      else                bus.fifo_rdreq = ~bus.fifo_empty & (fill < 3'd2);
   end

   // NOTE: sequential state uses non-blocking assignments only; the data
   // registers are reset as well because msg_data must read 0 out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= RUN;
         occ         <= 2'd0;
         pend        <= 1'b0;
         word0       <= '0;
         word1       <= '0;
         throttle_q  <= 1'b0;
         words_fwd_q <= '0;
         stall_q     <= '0;
      end else begin
         pend <= bus.fifo_rdreq;
         if (pop) words_fwd_q <= words_fwd_q + 32'd1;
         if (stall && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;

         if (level >= HI_LVL)      throttle_q <= 1'b1;
         else if (level <= LO_LVL) throttle_q <= 1'b0;

         case (state)
            RUN: begin
               if (bus.flush) begin
                  state <= FLUSH;
                  occ   <= 2'd0;
               end else begin
                  case ({pend, pop})
                     2'b11: begin
                        if (occ == 2'd2) begin
                           word0 <= word1;
                           word1 <= bus.fifo_q;
                        end else begin
                           word0 <= bus.fifo_q;
                        end
                     end
                     2'b10: begin
                        if (occ == 2'd0) begin
                           word0 <= bus.fifo_q;
                           occ   <= 2'd1;
                        end else if (occ == 2'd1) begin
                           word1 <= bus.fifo_q;
                           occ   <= 2'd2;
                        end
                     end
                     2'b01: begin
                        word0 <= word1;
                        occ   <= occ - 2'd1;
                     end
                     default: ;
                  endcase
               end
            end
            FLUSH: begin
               // Words landing while draining are dropped; occ stays 0.
               if (!bus.flush && bus.fifo_empty && !pend) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // A landing word must always find a free slot.
   assert property (@(posedge clk) disable iff (reset)
      !(state == RUN && !bus.flush && pend && !pop && occ == 2'd2));

endmodule
